// File: rtl/sig_ext_pkg.sv
// sig_ext_pkg: state encoding and index sizing shared by the pulse-extension scheduler.
package sig_ext_pkg;
   typedef enum logic [1:0] {IDLE, EXTEND, GAP} state_t;
   function automatic int idx_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/rr_arb.sv
// rr_arb: combinational round-robin pick, searching upward from ptr+1 with wrap.
module rr_arb import sig_ext_pkg::*; #(
   parameter int N = 4,
   localparam int IW = idx_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          any
);
   logic [N-1:0] hi, sel;
   // Requests above the pointer win; otherwise wrap to the lowest requester.
   always_comb begin
      hi = '0;
      for (int j = 0; j < N; j++) hi[j] = req[j] && (j > int'(ptr));
      sel = (|hi) ? hi : req;
      grant = '0;
      idx = '0;
      for (int j = N - 1; j >= 0; j--) begin
         if (sel[j]) begin
            grant = '0;
            grant[j] = 1'b1;
            idx = IW'(j);
         end
      end
      any = |req;
   end
endmodule

// File: rtl/sig_ext_sched.sv
// sig_ext_sched: round-robin shared pulse extender; one strobe of the requested
// length at a time, followed by a programmable low gap and a done pulse.
module sig_ext_sched import sig_ext_pkg::*; #(
   parameter int C_NUM_REQ = 4,
   parameter int C_LEN_WIDTH = 8,
   parameter int C_GAP_CYCLES = 1,
   localparam int IW = idx_w(C_NUM_REQ),
   localparam int GW = (C_GAP_CYCLES > 1) ? $clog2(C_GAP_CYCLES) : 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             ce,
   input  logic [C_NUM_REQ-1:0]             req_valid,
   input  logic [C_NUM_REQ*C_LEN_WIDTH-1:0] req_len,
   output logic [C_NUM_REQ-1:0]             req_ready,
   output logic                             ext_out,
   output logic [IW-1:0]                    ext_owner,
   output logic                             busy,
   output logic                             done,
   output logic [IW-1:0]                    done_id
);
   localparam logic [GW-1:0] G_LOAD = GW'((C_GAP_CYCLES > 0) ? C_GAP_CYCLES - 1 : 0);
   localparam state_t AFTER = (C_GAP_CYCLES > 0) ? GAP : IDLE;
   state_t state;
   logic [C_LEN_WIDTH-1:0] cnt, glen;
   logic [GW-1:0] gcnt;
   logic [IW-1:0] ptr, gidx;
   logic [C_NUM_REQ-1:0] grant;
   logic gany;
   rr_arb #(.N(C_NUM_REQ)) u_arb (
      .req(req_valid),
      .ptr(ptr),
      .grant(grant),
      .idx(gidx),
      .any(gany)
   );
   assign glen = req_len[int'(gidx) * C_LEN_WIDTH +: C_LEN_WIDTH];
   assign req_ready = (state == IDLE && ce) ? grant : '0;
   assign busy = state != IDLE;
   // done is only cleared on enabled edges, so it stretches across ce stalls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         gcnt <= '0;
         ptr <= IW'(C_NUM_REQ - 1);
         ext_out <= 1'b0;
         ext_owner <= '0;
         done <= 1'b0;
         done_id <= '0;
      end else if (ce) begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (gany) begin
                  ext_owner <= gidx;
                  ptr <= gidx;
                  if (glen != '0) begin
                     cnt <= glen - 1'b1;
                     ext_out <= 1'b1;
                     state <= EXTEND;
                  end else begin
                     done <= 1'b1;
                     done_id <= gidx;
                     gcnt <= G_LOAD;
                     state <= AFTER;
                  end
               end
            end
            EXTEND: begin
               if (cnt == '0) begin
                  ext_out <= 1'b0;
                  done <= 1'b1;
                  done_id <= ext_owner;
                  gcnt <= G_LOAD;
                  state <= AFTER;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            GAP: begin
               if (gcnt == '0) state <= IDLE;
               else gcnt <= gcnt - 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
